// File: rtl/mem_ctrl.sv
// mem_ctrl: byte-serial memory controller / arbiter.
// Shares the single 8-bit RAM/IO port between instruction fetch (IF) and the
// data-memory stage (MEM). Each 1/2/4-byte access is serialised one byte per
// cycle; the assembled word is returned with a one-cycle done pulse.
//
// Ports:
//   clk_in, rst_in (async, active-low), rdy_in (low freezes the controller)
//   IF  : if_req_in, if_addr_in -> if_done_out, if_data_out
//   MEM : mem_req_in, mem_wr_in, mem_len_in, mem_addr_in, mem_wdata_in
//         -> mem_done_out, mem_rdata_out
//   flush_in          : EX redirect, aborts an IF read
//   io_buffer_full_in : stalls stores to the IO region
//   RAM : ram_din_in (one cycle after address), ram_dout_out, ram_a_out, ram_wr_out
module mem_ctrl #(
    parameter logic [31:0] IO_MASK = 32'h0003_0000
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        if_req_in,
    input  logic [31:0] if_addr_in,
    output logic        if_done_out,
    output logic [31:0] if_data_out,
    input  logic        mem_req_in,
    input  logic        mem_wr_in,
    input  logic [1:0]  mem_len_in,
    input  logic [31:0] mem_addr_in,
    input  logic [31:0] mem_wdata_in,
    output logic        mem_done_out,
    output logic [31:0] mem_rdata_out,
    input  logic        flush_in,
    input  logic        io_buffer_full_in,
    input  logic [7:0]  ram_din_in,
    output logic [7:0]  ram_dout_out,
    output logic [31:0] ram_a_out,
    output logic        ram_wr_out
);

    typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;

    // Latched request; requester inputs are ignored once an access starts.
    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [2:0]  len;     // byte count N: 1, 2 or 4
        logic        is_mem;  // owner: 1 = MEM, 0 = IF
    } req_t;

    function automatic logic [2:0] len_to_n(input logic [1:0] len);
        case (len)
            2'd0:    return 3'd1;
            2'd1:    return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

    state_t      state, state_nxt;
    req_t        req;
    logic [2:0]  step;
    logic [31:0] rbuf;
    logic [31:0] rword;
    logic [31:0] byte_addr;
    logic        io_stall;
    logic        accept_mem, accept_if, step_inc, finish, abort;

    assign byte_addr = req.addr + {29'd0, step};
    assign io_stall  = ((req.addr & IO_MASK) == IO_MASK) && io_buffer_full_in;

    always_comb begin
        state_nxt    = state;
        accept_mem   = 1'b0;
        accept_if    = 1'b0;
        step_inc     = 1'b0;
        finish       = 1'b0;
        abort        = 1'b0;
        ram_a_out    = 32'd0;
        ram_wr_out   = 1'b0;
        ram_dout_out = 8'd0;
        rword        = rbuf;
        case (state)
            IDLE: begin
                // One-cycle cooldown after a done pulse lets the requester drop req.
                if (!if_done_out && !mem_done_out) begin
                    if (mem_req_in) begin
                        accept_mem = 1'b1;
                        state_nxt  = mem_wr_in ? WRITE : READ;
                    end else if (if_req_in && !flush_in) begin
                        accept_if = 1'b1;
                        state_nxt = READ;
                    end
                end
            end
            READ: begin
                if (flush_in && !req.is_mem) begin
                    abort     = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    if (step < req.len) ram_a_out = byte_addr;
                    // Byte for address step-1 arrives this cycle.
                    case (step)
                        3'd1:    rword[7:0]   = ram_din_in;
                        3'd2:    rword[15:8]  = ram_din_in;
                        3'd3:    rword[23:16] = ram_din_in;
                        3'd4:    rword[31:24] = ram_din_in;
                        default: ;
                    endcase
                    if (step == req.len) begin
                        finish    = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        step_inc = 1'b1;
                    end
                end
            end
            WRITE: begin
                ram_a_out = byte_addr;
                case (step[1:0])
                    2'd0: ram_dout_out = req.wdata[7:0];
                    2'd1: ram_dout_out = req.wdata[15:8];
                    2'd2: ram_dout_out = req.wdata[23:16];
                    2'd3: ram_dout_out = req.wdata[31:24];
                endcase
                if (!io_stall) begin
                    ram_wr_out = 1'b1;
                    if (step == req.len - 3'd1) begin
                        finish    = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        step_inc = 1'b1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
        // Address stays put while frozen so RAM data remains valid; never write.
        if (!rdy_in) ram_wr_out = 1'b0;
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state         <= IDLE;
            req           <= '0;
            step          <= 3'd0;
            rbuf          <= 32'd0;
            if_done_out   <= 1'b0;
            if_data_out   <= 32'd0;
            mem_done_out  <= 1'b0;
            mem_rdata_out <= 32'd0;
        end else if (rdy_in) begin
            state <= state_nxt;
            if (state == IDLE) begin
                if_done_out  <= 1'b0;
                mem_done_out <= 1'b0;
            end
            if (accept_mem) begin
                req  <= '{addr: mem_addr_in, wdata: mem_wdata_in,
                          len: len_to_n(mem_len_in), is_mem: 1'b1};
                step <= 3'd0;
                rbuf <= 32'd0;
            end else if (accept_if) begin
                req  <= '{addr: if_addr_in, wdata: 32'd0, len: 3'd4, is_mem: 1'b0};
                step <= 3'd0;
                rbuf <= 32'd0;
            end
            if (step_inc) step <= step + 3'd1;
            if (state == READ && !abort) rbuf <= rword;
            if (finish) begin
                if (req.is_mem) begin
                    mem_done_out <= 1'b1;
                    if (state == READ) mem_rdata_out <= rword;
                end else begin
                    if_done_out <= 1'b1;
                    if_data_out <= rword;
                end
            end
        end
    end

endmodule
